// File: rtl/sort4_cmp_ctrl.sv
// sort4_cmp_ctrl: bubble-sorts a 4-beat batch of 4-bit operands through one shared gate-level comparator.
// Build option SORT_EARLY_EXIT_EN: leave SORT after the first pass that performs no swap.

module comparator_4bit_gates (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_a_gt_b,
  output logic       o_a_lt_b,
  output logic       o_a_eq_b
);
  logic [3:0] w_eq;

  assign w_eq     = ~(i_a ^ i_b);
  assign o_a_gt_b = (i_a[3] & ~i_b[3])
                  | (w_eq[3] & i_a[2] & ~i_b[2])
                  | (w_eq[3] & w_eq[2] & i_a[1] & ~i_b[1])
                  | (w_eq[3] & w_eq[2] & w_eq[1] & i_a[0] & ~i_b[0]);
  assign o_a_lt_b = (~i_a[3] & i_b[3])
                  | (w_eq[3] & ~i_a[2] & i_b[2])
                  | (w_eq[3] & w_eq[2] & ~i_a[1] & i_b[1])
                  | (w_eq[3] & w_eq[2] & w_eq[1] & ~i_a[0] & i_b[0]);
  assign o_a_eq_b = &w_eq;
endmodule

module sort4_cmp_ctrl #(
  parameter bit ORDER_DESC = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] swap_cnt,
  output logic       busy,
  output logic [1:0] dbg_state
);
  // Both streams: a beat transfers on the rising edge where valid && ready; ready never depends on valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_m [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [1:0] r_j;
  logic [1:0] r_pass;
  logic [2:0] r_swap_cnt;

  logic [1:0] w_j1;
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic       w_gt;
  logic       w_lt;
  logic       w_eq;
  logic       w_swap;
  logic       w_pass_end;
  logic       w_sort_done;
  logic       w_in_fire;
  logic       w_out_fire;

  assign w_j1 = r_j + 2'd1;
  assign w_a  = r_m[r_j];
  assign w_b  = r_m[w_j1];

  comparator_4bit_gates u_cmp (
    .i_a      (w_a),
    .i_b      (w_b),
    .o_a_gt_b (w_gt),
    .o_a_lt_b (w_lt),
    .o_a_eq_b (w_eq)
  );

  // Equal pairs never swap, keeping the sort stable.
  assign w_swap     = !w_eq && (ORDER_DESC ? w_lt : w_gt);
  assign w_pass_end = (r_j == 2'd2);

`ifdef SORT_EARLY_EXIT_EN
  logic r_pass_swapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_swapped <= 1'b0;
    end else if (w_in_fire) begin
      r_pass_swapped <= 1'b0;
    end else if (r_state == S_SORT) begin
      r_pass_swapped <= w_pass_end ? 1'b0 : (r_pass_swapped | w_swap);
    end
  end

  assign w_sort_done = w_pass_end && ((r_pass == 2'd2) || !(r_pass_swapped || w_swap));
`else
  assign w_sort_done = w_pass_end && (r_pass == 2'd2);
`endif

  assign w_in_fire  = in_valid && (r_state == S_IDLE);
  assign w_out_fire = out_ready && (r_state == S_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_in_fire && r_wr_ptr == 2'd3) w_next = S_SORT;
      S_SORT:  if (w_sort_done) w_next = S_OUT;
      S_OUT:   if (w_out_fire && r_rd_ptr == 2'd3) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_m[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_j        <= '0;
      r_pass     <= '0;
      r_swap_cnt <= '0;
    end else begin
      if (w_in_fire) begin
        r_m[r_wr_ptr] <= in_data;
        r_wr_ptr      <= r_wr_ptr + 2'd1;
        // The previous batch's count stays visible until the new batch starts arriving.
        if (r_wr_ptr == 2'd0) r_swap_cnt <= '0;
        if (r_wr_ptr == 2'd3) begin
          r_j    <= '0;
          r_pass <= '0;
        end
      end
      if (r_state == S_SORT) begin
        if (w_swap) begin
          r_m[r_j]   <= w_b;
          r_m[w_j1]  <= w_a;
          r_swap_cnt <= r_swap_cnt + 3'd1;
        end
        r_j <= w_pass_end ? 2'd0 : w_j1;
        if (w_pass_end)  r_pass   <= r_pass + 2'd1;
        if (w_sort_done) r_rd_ptr <= '0;
      end
      if (w_out_fire) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
        if (r_rd_ptr == 2'd3) r_wr_ptr <= '0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign out_data  = (r_state == S_OUT) ? r_m[r_rd_ptr] : 4'd0;
  assign swap_cnt  = r_swap_cnt;
  assign busy      = (r_state == S_SORT) || (r_state == S_OUT);
  assign dbg_state = r_state;
endmodule
